ps2_scan_ctrl: RTL and testbench
================================

# ps2_scan_ctrl

Sequencing controller between the PS/2 receiver FIFO and the keyboard display logic. It pops bytes through the receiver's ready/nextdata_n handshake and parses the scan-code grammar: optional E0 (extended), optional F0 (break), then a code byte. It emits one-cycle key events with make/break/extended/repeat qualifiers. It keeps held-key state and a press counter for the segment display.

## Interface
- CNT_W, 8, width of the press counter (wraps modulo 2^CNT_W)
- PREFIX_TO, 65535, idle cycles after a prefix byte before pending prefixes are discarded (must be ≥1)
- clk  in  1  system clock
- clrn  in  1  reset, synchronous, active-low
- ps2_data  in  8  FIFO head byte from receiver, valid while ps2_ready=1
- ps2_ready  in  1  receiver FIFO non-empty
- ps2_overflow  in  1  receiver FIFO overflow indication
- ps2_nextdata_n  out  1  active-low pop strobe to receiver, registered
- key_valid  out  1  one-cycle key event strobe
- key_code  out  8  code byte of last event
- key_break  out  1  last event is a release
- key_ext  out  1  last event was E0-prefixed
- key_repeat  out  1  last event is a typematic repeat make
- key_held  out  1  a key is currently held
- key_cnt  out  CNT_W  number of distinct presses since reset
- fifo_ovf  out  1  sticky ps2_overflow capture

## Operation
- FSM states: IDLE, POP.
  - IDLE: if ps2_ready=1, latch ps2_data into byte_q, drive ps2_nextdata_n←0, go to POP. Otherwise stay in IDLE.
  - POP: drive ps2_nextdata_n←1, decode byte_q, return to IDLE.
- Decode of byte_q:
  - F0: set brk_pend.
  - E0: set ext_pend.
  - E1: clear both pending flags; the byte is dropped.
  - Any other byte is a code byte: generate an event with key_break=brk_pend and key_ext=ext_pend, then clear both pending flags.
- Repeated prefixes are idempotent (F0 F0 is the same as F0). F0 E0 ordering is accepted and yields break+ext.
- Held tracking uses held_code[7:0] and held_ext.
  - Make event with key_held=1 and matching code+ext: key_repeat=1, key_cnt unchanged.
  - Make event otherwise: key_repeat=0, key_cnt+1, held_code/held_ext updated, key_held←1.
  - Break event matching held_code+held_ext: key_held←0. A non-matching break leaves key_held unchanged.
- key_code, key_break, key_ext and key_repeat hold their values until the next event.
- Prefix timeout: a counter loads PREFIX_TO on each prefix byte and decrements in IDLE while ps2_ready=0. At 0, both pending flags clear. The counter is inactive when no prefix is pending.
- fifo_ovf is set when ps2_overflow=1 and clears only on reset.

## Timing
- Reset (clrn=0 at an edge):
  - State IDLE, ps2_nextdata_n=1.
  - key_valid, key_break, key_ext, key_repeat, key_held and fifo_ovf = 0.
  - key_code=8'h00, key_cnt=0; pending flags and timeout cleared.
  - Reset mid-POP aborts the pop: ps2_nextdata_n returns to 1 at the same edge, and the FIFO byte is not consumed twice.
- ps2_ready=1 sampled in cycle N: ps2_nextdata_n=0 during cycle N+1 only, and the FIFO advances at the end of N+1. key_valid is high in cycle N+2.
- ps2_ready is re-sampled in cycle N+2, so maximum throughput is one byte per 2 cycles. ps2_nextdata_n is never low for two consecutive cycles.
- ps2_ready=0 in IDLE: no strobe, no state change except the timeout decrement.
- key_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- Timeout expiry and a byte arriving in the same cycle: the byte is decoded with prefixes already cleared.

## Configuration
- PS2_SCAN_CTRL_EXT_EN
  - Defined: E0 handling as described above.
  - Undefined: E0 bytes are popped and dropped, ext_pend never sets, key_ext is constant 0, and held matching compares code only.

## Structure
- Shared package ps2_pkg holds:
  - Constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_PAUSE=8'hE1.
  - The FSM state typedef (IDLE, POP).
- One sub-module, ps2_prefix_timer (load/decrement/expire of PREFIX_TO), instantiated once. Everything else stays in ps2_scan_ctrl.

## Test plan
- FIFO bytes 1C, F0, 1C:
  - key_valid ×2.
  - First event: key_code=1C, key_break=0, key_cnt=1, key_held=1.
  - Second event: key_code=1C, key_break=1, key_held=0.
- Bytes 1C, 1C, 1C (typematic), then F0 1C: key_cnt=1, second and third events key_repeat=1, final key_held=0.
- With EXT_EN, bytes E0 75, E0 F0 75:
  - Events key_ext=1, code 75, make then break.
  - Without EXT_EN: key_ext=0 on both events.
- ps2_ready held high with 6 bytes queued:
  - ps2_nextdata_n pulses exactly 6 times, spaced 2 cycles apart.
  - key_valid follows each pulse by 1 cycle.
- PREFIX_TO=4, byte F0, then idle 10 cycles, then 2D: event key_break=0, key_code=2D. Same sequence with 2 idle cycles gives key_break=1.
- Other checks:
  - key_cnt reaches 255 → next distinct make wraps it to 0.
  - ps2_overflow pulsed once → fifo_ovf stays 1 until clrn=0.
  - clrn=0 during POP → ps2_nextdata_n=1 at that edge.

Source files
------------

// File: rtl/ps2_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared definitions for the PS/2 scan-code controller: protocol
//             prefix byte values, the sequencing FSM state type and a small
//             classification helper for prefix bytes.
//  Ports    : none (package)
//  Config   : PS2_SCAN_CTRL_EXT_EN (consumed by ps2_scan_ctrl)
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Scan-code set 2 prefix bytes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Two-state pop sequencer
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        POP  = 1'b1
    } ps2_state_e;

    // True for bytes that only qualify the following code byte
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_ctrl_if
//  Purpose  : Bundles the receiver FIFO handshake (ps2_data / ps2_ready /
//             ps2_overflow / ps2_nextdata_n) and the key-event outputs of the
//             scan controller.
//  Modports : master - the scan controller (pops the FIFO, emits events)
//             slave  - the surrounding logic (FIFO side + event consumer)
//  Params   : CNT_W  width of the press counter
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_scan_ctrl_if #(
    parameter int CNT_W = 8
);
    // Receiver FIFO side
    logic [7:0]       ps2_data;
    logic             ps2_ready;
    logic             ps2_overflow;
    logic             ps2_nextdata_n;

    // Key event side
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_break;
    logic             key_ext;
    logic             key_repeat;
    logic             key_held;
    logic [CNT_W-1:0] key_cnt;
    logic             fifo_ovf;

    modport master (
        input  ps2_data, ps2_ready, ps2_overflow,
        output ps2_nextdata_n,
        output key_valid, key_code, key_break, key_ext, key_repeat,
        output key_held, key_cnt, fifo_ovf
    );

    modport slave (
        output ps2_data, ps2_ready, ps2_overflow,
        input  ps2_nextdata_n,
        input  key_valid, key_code, key_break, key_ext, key_repeat,
        input  key_held, key_cnt, fifo_ovf
    );

endinterface : ps2_scan_ctrl_if
`default_nettype wire

// File: rtl/ps2_scan_ctrl_prefix_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_prefix_timer
//  Purpose  : Idle timeout for pending scan-code prefixes. Loads PREFIX_TO
//             when a prefix byte is decoded, counts down on idle cycles while
//             a prefix is pending, and flags expiry once it reaches zero.
//  Ports    : clk, clrn      clock / synchronous active-low reset
//             i_load         prefix byte decoded this cycle
//             i_dec          idle cycle (sequencer idle, FIFO empty)
//             i_active       a prefix is currently pending
//             o_expire       pending prefixes must be discarded
//  Params   : PREFIX_TO      idle cycles before expiry (>= 1)
//  Revision : 1.0  initial release
// ============================================================================
module ps2_prefix_timer #(
    parameter int PREFIX_TO = 65535
) (
    input  logic clk,
    input  logic clrn,
    input  logic i_load,
    input  logic i_dec,
    input  logic i_active,
    output logic o_expire
);

    localparam int               c_TO_W = (PREFIX_TO < 2) ? 1 : $clog2(PREFIX_TO + 1);
    localparam logic [c_TO_W-1:0] c_LOAD = c_TO_W'(PREFIX_TO);

    logic [c_TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_LOAD;
        end else if (i_active && i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_TO_W'(1);
        end
    end

    // A stale zero count is harmless: expiry only matters while a prefix
    // is pending, and every new prefix reloads the counter.
    assign o_expire = i_active && (r_cnt == '0);

endmodule : ps2_prefix_timer
`default_nettype wire

// File: rtl/ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_ctrl
//  Purpose  : Pops bytes from the PS/2 receiver FIFO and parses the scan-code
//             grammar [E0] [F0] code. Emits one-cycle key events with
//             make/break/extended/repeat qualifiers, tracks the held key and
//             counts distinct presses.
//  Ports    : clk            system clock
//             clrn           synchronous active-low reset
//             bus (master)   ps2_data, ps2_ready, ps2_overflow (in)
//                            ps2_nextdata_n, key_valid, key_code, key_break,
//                            key_ext, key_repeat, key_held, key_cnt,
//                            fifo_ovf (out)
//  Params   : CNT_W          press counter width (wraps)
//             PREFIX_TO      prefix idle timeout in cycles (>= 1)
//  Config   : PS2_SCAN_CTRL_EXT_EN  enables E0 (extended) handling; when
//             undefined E0 is dropped, key_ext is 0 and held matching
//             compares the code only.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PREFIX_TO = 65535
) (
    input  logic                   clk,
    input  logic                   clrn,
    ps2_scan_ctrl_if.master        bus
);

`ifdef PS2_SCAN_CTRL_EXT_EN
    localparam logic c_EXT_EN = 1'b1;
`else
    localparam logic c_EXT_EN = 1'b0;
`endif

    ps2_state_e       r_state;
    logic [7:0]       r_byte;
    logic             r_nextdata_n;
    logic             r_brk_pend;
    logic             r_ext_pend;
    logic             r_key_valid;
    logic [7:0]       r_key_code;
    logic             r_key_break;
    logic             r_key_ext;
    logic             r_key_repeat;
    logic             r_key_held;
    logic [CNT_W-1:0] r_key_cnt;
    logic [7:0]       r_held_code;
    logic             r_held_ext;
    logic             r_fifo_ovf;

    logic w_is_break;
    logic w_is_ext;
    logic w_is_pause;
    logic w_evt_ext;
    logic w_match;
    logic w_timer_load;
    logic w_timer_dec;
    logic w_pending;
    logic w_expire;

    assign w_is_break = (r_byte == PS2_BREAK);
    assign w_is_ext   = (r_byte == PS2_EXT);
    assign w_is_pause = (r_byte == PS2_PAUSE);

    // Extended qualifier of the event being decoded (forced 0 when the
    // extended feature is compiled out).
    assign w_evt_ext  = c_EXT_EN & r_ext_pend;

    // Current code byte refers to the held key
    assign w_match    = (r_byte == r_held_code) &&
                        (!c_EXT_EN || (r_held_ext == w_evt_ext));

    // Only prefixes that actually become pending arm the timeout
    assign w_timer_load = (r_state == POP) &&
                          (w_is_break || (c_EXT_EN && is_prefix(r_byte)));
    assign w_timer_dec  = (r_state == IDLE) && !bus.ps2_ready;
    assign w_pending    = r_brk_pend | r_ext_pend;

    ps2_prefix_timer #(
        .PREFIX_TO (PREFIX_TO)
    ) u_prefix_timer (
        .clk      (clk),
        .clrn     (clrn),
        .i_load   (w_timer_load),
        .i_dec    (w_timer_dec),
        .i_active (w_pending),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_byte       <= 8'h00;
            r_nextdata_n <= 1'b1;
            r_brk_pend   <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_key_valid  <= 1'b0;
            r_key_code   <= 8'h00;
            r_key_break  <= 1'b0;
            r_key_ext    <= 1'b0;
            r_key_repeat <= 1'b0;
            r_key_held   <= 1'b0;
            r_key_cnt    <= '0;
            r_held_code  <= 8'h00;
            r_held_ext   <= 1'b0;
            r_fifo_ovf   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;

            if (bus.ps2_overflow) begin
                r_fifo_ovf <= 1'b1;
            end

            // Expiry is only possible while idle, so it never collides with
            // a decode; a byte sampled in the same cycle sees cleared flags.
            if (w_expire) begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (bus.ps2_ready) begin
                        r_byte       <= bus.ps2_data;
                        r_nextdata_n <= 1'b0;
                        r_state      <= POP;
                    end
                end

                POP: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= IDLE;

                    if (w_is_break) begin
                        r_brk_pend <= 1'b1;
                    end else if (w_is_ext) begin
                        if (c_EXT_EN) begin
                            r_ext_pend <= 1'b1;
                        end
                    end else if (w_is_pause) begin
                        r_brk_pend <= 1'b0;
                        r_ext_pend <= 1'b0;
                    end else begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= r_byte;
                        r_key_break <= r_brk_pend;
                        r_key_ext   <= w_evt_ext;
                        r_brk_pend  <= 1'b0;
                        r_ext_pend  <= 1'b0;

                        if (!r_brk_pend) begin
                            if (r_key_held && w_match) begin
                                // Typematic repeat of the held key
                                r_key_repeat <= 1'b1;
                            end else begin
                                r_key_repeat <= 1'b0;
                                r_key_cnt    <= r_key_cnt + CNT_W'(1);
                                r_held_code  <= r_byte;
                                r_held_ext   <= w_evt_ext;
                                r_key_held   <= 1'b1;
                            end
                        end else begin
                            r_key_repeat <= 1'b0;
                            if (w_match) begin
                                r_key_held <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ps2_nextdata_n = r_nextdata_n;
    assign bus.key_valid      = r_key_valid;
    assign bus.key_code       = r_key_code;
    assign bus.key_break      = r_key_break;
    assign bus.key_ext        = r_key_ext;
    assign bus.key_repeat     = r_key_repeat;
    assign bus.key_held       = r_key_held;
    assign bus.key_cnt        = r_key_cnt;
    assign bus.fifo_ovf       = r_fifo_ovf;

endmodule : ps2_scan_ctrl
`default_nettype wire

// File: tb/tb_ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_scan_ctrl
//  Purpose  : Self-checking bench for ps2_scan_ctrl. A queue models the
//             receiver FIFO; a vector table drives single bytes and checks
//             the resulting event, followed by throughput, prefix timeout,
//             counter wrap, overflow and reset-during-pop sequences.
//  Config   : PS2_SCAN_CTRL_EXT_EN selects the expected key_ext values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_scan_ctrl;

`ifdef PS2_SCAN_CTRL_EXT_EN
    localparam bit c_EXT = 1'b1;
`else
    localparam bit c_EXT = 1'b0;
`endif

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    ps2_scan_ctrl_if #(.CNT_W(8)) bus ();

    ps2_scan_ctrl #(
        .CNT_W     (8),
        .PREFIX_TO (4)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.master)
    );

    typedef struct {
        logic [7:0] b;
        bit         v;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        bit         rpt;
        bit         held;
        logic [7:0] cnt;
    } vec_t;

    vec_t       vt[24];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] fifo[$];
    int         tick_no = 0;
    int         pop_ticks[$];
    int         evt_ticks[$];
    bit         prev_pop = 1'b0;
    int         evt_count = 0;
    logic [7:0] ev_code;
    logic       ev_brk, ev_ext, ev_rpt;
    int         exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.ps2_ready = (fifo.size() != 0);
        bus.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: observe at the falling edge, advance the FIFO model on a
    // pop strobe, record events, then refresh the FIFO head.
    task automatic tick();
        @(negedge clk);
        tick_no++;
        if (bus.ps2_nextdata_n === 1'b0) begin
            check("nextdata_single", 32'(prev_pop), 32'd0);
            prev_pop = 1'b1;
            pop_ticks.push_back(tick_no);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end else begin
            prev_pop = 1'b0;
        end
        if (bus.key_valid === 1'b1) begin
            evt_count++;
            evt_ticks.push_back(tick_no);
            ev_code = bus.key_code;
            ev_brk  = bus.key_break;
            ev_ext  = bus.key_ext;
            ev_rpt  = bus.key_repeat;
        end
        drive();
    endtask

    // Queue one byte, wait for its pop, then allow the event to appear.
    // idle_extra adds idle cycles after the event window.
    task automatic apply(input logic [7:0] b, input int idle_extra);
        evt_count = 0;
        fifo.push_back(b);
        drive();
        for (int i = 0; i < 20 && fifo.size() != 0; i++) tick();
        if (fifo.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: byte %0h still queued, expected popped", b);
            fifo.delete();
            drive();
        end
        tick();
        tick();
        repeat (idle_extra) tick();
    endtask

    task automatic check_event(input string name, input logic [7:0] code, input bit brk,
                               input bit ext, input bit rpt, input bit held, input logic [7:0] cnt);
        check({name, "_valid"}, 32'(evt_count), 32'd1);
        check({name, "_code"},  32'(ev_code), 32'(code));
        check({name, "_break"}, 32'(ev_brk), 32'(brk));
        check({name, "_ext"},   32'(ev_ext), 32'(ext));
        check({name, "_rpt"},   32'(ev_rpt), 32'(rpt));
        check({name, "_held"},  32'(bus.key_held), 32'(held));
        check({name, "_cnt"},   32'(bus.key_cnt), 32'(cnt));
    endtask

    initial begin
        //             byte   v  code   brk ext    rpt held cnt
        vt[0]  = '{8'h1C, 1, 8'h1C, 0, 0,     0, 1, 8'd1};
        vt[1]  = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd1};
        vt[2]  = '{8'h1C, 1, 8'h1C, 1, 0,     0, 0, 8'd1};
        vt[3]  = '{8'h1C, 1, 8'h1C, 0, 0,     0, 1, 8'd2};
        vt[4]  = '{8'h1C, 1, 8'h1C, 0, 0,     1, 1, 8'd2};
        vt[5]  = '{8'h1C, 1, 8'h1C, 0, 0,     1, 1, 8'd2};
        vt[6]  = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd2};
        vt[7]  = '{8'h1C, 1, 8'h1C, 1, 0,     0, 0, 8'd2};
        vt[8]  = '{8'hE0, 0, 8'h00, 0, 0,     0, 0, 8'd2};
        vt[9]  = '{8'h75, 1, 8'h75, 0, c_EXT, 0, 1, 8'd3};
        vt[10] = '{8'hE0, 0, 8'h00, 0, 0,     0, 1, 8'd3};
        vt[11] = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd3};
        vt[12] = '{8'h75, 1, 8'h75, 1, c_EXT, 0, 0, 8'd3};
        vt[13] = '{8'hF0, 0, 8'h00, 0, 0,     0, 0, 8'd3};
        vt[14] = '{8'h2D, 1, 8'h2D, 1, 0,     0, 0, 8'd3};
        vt[15] = '{8'hF0, 0, 8'h00, 0, 0,     0, 0, 8'd3};
        vt[16] = '{8'hE1, 0, 8'h00, 0, 0,     0, 0, 8'd3};
        vt[17] = '{8'h2D, 1, 8'h2D, 0, 0,     0, 1, 8'd4};
        vt[18] = '{8'h2E, 1, 8'h2E, 0, 0,     0, 1, 8'd5};
        vt[19] = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd5};
        vt[20] = '{8'h2D, 1, 8'h2D, 1, 0,     0, 1, 8'd5};
        vt[21] = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd5};
        vt[22] = '{8'hF0, 0, 8'h00, 0, 0,     0, 1, 8'd5};
        vt[23] = '{8'h2E, 1, 8'h2E, 1, 0,     0, 0, 8'd5};

        bus.ps2_overflow = 1'b0;
        drive();
        repeat (3) tick();
        check("rst_nextdata", 32'(bus.ps2_nextdata_n), 32'd1);
        check("rst_valid",    32'(bus.key_valid), 32'd0);
        check("rst_code",     32'(bus.key_code), 32'd0);
        check("rst_flags",    {28'd0, bus.key_break, bus.key_ext, bus.key_repeat, bus.key_held}, 32'd0);
        check("rst_cnt",      32'(bus.key_cnt), 32'd0);
        check("rst_ovf",      32'(bus.fifo_ovf), 32'd0);
        clrn = 1'b1;
        tick();

        // Table-driven single bytes
        for (int i = 0; i < 24; i++) begin
            apply(vt[i].b, 0);
            if (vt[i].v) begin
                check_event($sformatf("vec%0d", i), vt[i].code, vt[i].brk, vt[i].ext,
                            vt[i].rpt, vt[i].held, vt[i].cnt);
            end else begin
                check($sformatf("vec%0d_noevt", i), 32'(evt_count), 32'd0);
                check($sformatf("vec%0d_held", i), 32'(bus.key_held), 32'(vt[i].held));
                check($sformatf("vec%0d_cnt", i), 32'(bus.key_cnt), 32'(vt[i].cnt));
            end
        end

        // Back-to-back throughput with six queued bytes
        pop_ticks.delete();
        evt_ticks.delete();
        evt_count = 0;
        for (int i = 0; i < 6; i++) fifo.push_back(8'h40 + 8'(i));
        drive();
        repeat (20) tick();
        check("tput_pops", 32'(pop_ticks.size()), 32'd6);
        check("tput_evts", 32'(evt_ticks.size()), 32'd6);
        for (int i = 1; i < 6 && i < pop_ticks.size(); i++)
            check($sformatf("tput_space%0d", i), 32'(pop_ticks[i] - pop_ticks[i-1]), 32'd2);
        for (int i = 0; i < 6 && i < pop_ticks.size() && i < evt_ticks.size(); i++)
            check($sformatf("tput_lag%0d", i), 32'(evt_ticks[i] - pop_ticks[i]), 32'd1);
        check("tput_code", 32'(ev_code), 32'h45);
        check("tput_cnt",  32'(bus.key_cnt), 32'd11);

        // Prefix timeout (PREFIX_TO=4): idle decrements = 1 + idle_extra
        apply(8'hF0, 9);
        apply(8'h2D, 0);
        check_event("to_long", 8'h2D, 0, 0, 0, 1, 8'd12);
        apply(8'hF0, 1);
        apply(8'h2D, 0);
        check_event("to_short", 8'h2D, 1, 0, 0, 0, 8'd12);
        apply(8'hF0, 3);
        apply(8'h2D, 0);
        check_event("to_edge4", 8'h2D, 0, 0, 0, 1, 8'd13);
        apply(8'hF0, 2);
        apply(8'h2D, 0);
        check_event("to_edge3", 8'h2D, 1, 0, 0, 0, 8'd13);

        // Counter wrap
        exp_cnt = 13;
        while (exp_cnt < 255) begin
            apply((exp_cnt % 2 == 0) ? 8'h21 : 8'h20, 0);
            exp_cnt++;
        end
        check("wrap_255", 32'(bus.key_cnt), 32'd255);
        apply(8'h22, 0);
        check_event("wrap_0", 8'h22, 0, 0, 0, 1, 8'd0);

        // Sticky overflow
        check("ovf_before", 32'(bus.fifo_ovf), 32'd0);
        bus.ps2_overflow = 1'b1;
        tick();
        bus.ps2_overflow = 1'b0;
        repeat (5) tick();
        check("ovf_sticky", 32'(bus.fifo_ovf), 32'd1);

        // Reset asserted while the pop strobe is active
        evt_count = 0;
        fifo.push_back(8'h33);
        drive();
        tick();
        check("rpop_strobe", 32'(bus.ps2_nextdata_n), 32'd0);
        clrn = 1'b0;
        tick();
        check("rpop_nextdata", 32'(bus.ps2_nextdata_n), 32'd1);
        check("rpop_cnt",      32'(bus.key_cnt), 32'd0);
        check("rpop_held",     32'(bus.key_held), 32'd0);
        check("rpop_ovf",      32'(bus.fifo_ovf), 32'd0);
        check("rpop_code",     32'(bus.key_code), 32'd0);
        clrn = 1'b1;
        repeat (4) tick();
        check("rpop_noevt",    32'(evt_count), 32'd0);
        check("rpop_idle",     32'(bus.ps2_nextdata_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ps2_scan_ctrl
`default_nettype wire
